// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants: instruction width, opcode and funct field
// positions, and the sequential PC step. Decode imports the same constants.
// Also holds a saturating adder used by the optional performance counters.
package fetch_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned PC_STEP    = 4;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch stage bus bundle: instruction-memory request (valid/ready),
// instruction-memory response (valid only, in order), branch/jump redirect
// pulse, and the decode-side valid/ready handshake with instr/pc/fields.
//   master : the fetch unit
//   slave  : memory + decode + branch resolution (the environment)
interface fetch_queue_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned AW = 32
);

  logic                           imem_req_valid;
  logic                           imem_req_ready;
  logic [AW-1:0]                  imem_req_addr;
  logic                           imem_rsp_valid;
  logic [INSTR_W-1:0]             imem_rsp_data;
  logic                           redirect_valid;
  logic [AW-1:0]                  redirect_pc;
  logic                           dec_valid;
  logic                           dec_ready;
  logic [INSTR_W-1:0]             dec_instr;
  logic [AW-1:0]                  dec_pc;
  logic [OPCODE_MSB-OPCODE_LSB:0] dec_opcode;
  logic [FUNCT_MSB-FUNCT_LSB:0]   dec_funct;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct,
    output dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with fall-through head (head_data is read
// combinationally from storage). Pointers carry an extra wrap bit so that
// full and empty are distinguishable; DEPTH must be a power of two >= 2.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   push, push_data      : write; accepted when not full or when popping
//   pop                  : read; ignored when empty
//   flush                : discard all entries (wins over push/pop)
//   head_data            : oldest entry
//   count, full, empty   : occupancy status
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW:0]      wr_ptr;
  logic [IW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign full      = (count == (IW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr[IW-1:0]] <= push_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (reset || flush)
    !(push && full && !pop));

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage feeding decode. Owns the PC, issues word reads to
// instruction memory under a credit rule (in-flight + buffered < DEPTH),
// buffers returned words with their PCs and presents them to decode.
// A redirect flushes the buffer, retargets the PC and marks every
// outstanding response stale so it is dropped on arrival.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : fetch_queue_unit_if.master (imem req/rsp, redirect, decode)
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters:
//   perf_fetched : instructions popped by decode
//   perf_stall   : cycles decode was ready but nothing valid
//   perf_flushed : words discarded (flushed entries + stale responses)
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_queue_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int unsigned    CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

  logic [AW-1:0]         fetch_pc;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic                  req_fire;
  logic                  rsp_drop;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pcq_full;
  logic                  pcq_empty;
  logic [AW-1:0]         rsp_pc;
  logic [INSTR_W+AW-1:0] fifo_head;
  logic [INSTR_W-1:0]    head_instr;

  assign occupancy          = {1'b0, inflight} + {1'b0, fifo_count};
  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (occupancy < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A response landing in the redirect cycle is already stale.
  assign rsp_drop = bus.redirect_valid || (drop_cnt != '0);
  assign push     = bus.imem_rsp_valid && !rsp_drop;
  assign pop      = bus.dec_valid && bus.dec_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[AW-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + AW'(PC_STEP);
    end
  end

  // Stale responses stay counted in inflight until they arrive, so a
  // redirect makes every outstanding response stale by setting drop_cnt
  // to inflight (minus the one arriving now); this stays exact when a
  // second redirect lands while earlier stale responses are pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      drop_cnt <= inflight - CW'(bus.imem_rsp_valid);
    end else if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // Issue-order PC queue: one entry per outstanding request, retired by
  // every response (kept or dropped), so its occupancy is the in-flight
  // count and its head is the PC of the arriving response.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AW)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (bus.imem_rsp_valid),
    .flush     (1'b0),
    .head_data (rsp_pc),
    .count     (inflight),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + AW)
  ) u_instr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({bus.imem_rsp_data, rsp_pc}),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_instr     = fifo_head[AW +: INSTR_W];
  assign bus.dec_valid  = !reset && !fifo_empty && !bus.redirect_valid;
  assign bus.dec_instr  = head_instr;
  assign bus.dec_pc     = fifo_head[AW-1:0];
  assign bus.dec_opcode = head_instr[OPCODE_MSB:OPCODE_LSB];
  assign bus.dec_funct  = head_instr[FUNCT_MSB:FUNCT_LSB];

  rsp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(bus.imem_rsp_valid && pcq_empty));
  req_over_credit: assert property (@(posedge clk) disable iff (reset)
    !(req_fire && pcq_full));
  buffer_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flush_inc;

  always_comb begin
    flush_inc = '0;
    if (bus.redirect_valid) flush_inc = 32'(fifo_count);
    if (bus.imem_rsp_valid && rsp_drop) flush_inc = flush_inc + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop) perf_fetched <= sat_add32(perf_fetched, 32'd1);
      if (bus.dec_ready && !bus.dec_valid) perf_stall <= sat_add32(perf_stall, 32'd1);
      perf_flushed <= sat_add32(perf_flushed, flush_inc);
    end
  end
`endif

endmodule
